pwm_hall_cfg_seq: RTL

PWM_HALL_CFG_SEQ -- requirements
Module: pwm_hall_cfg_seq

---
 rtl/pwm_hall_pkg.sv | 21 ++
 rtl/axil_wait_timer.sv | 26 ++
 rtl/pwm_hall_cfg_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pwm_hall_pkg.sv
// Shared types and constants for the pwm_hall register-configuration sequencer.
package pwm_hall_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WRESP,
    RD,
    RDATA,
    NEXT,
    FIN
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RESP    = 2'd1;
  localparam logic [1:0] ERR_CMP     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_wait_timer.sv
// Per-state handshake wait counter; expired flags the last allowed cycle.
module axil_wait_timer #(
  parameter int C_TIMEOUT = 256
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(C_TIMEOUT - 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                   cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (en && cnt != LAST)   cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/pwm_hall_cfg_seq.sv
// AXI4-Lite master that writes C_NUM_REGS configuration words to the pwm_hall
// slave, reads each one back, and reports pass/fail with the failing index.
module pwm_hall_cfg_seq
  import pwm_hall_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 32'h0000_0000,
  parameter int                            C_NUM_REGS         = 4,
  parameter int                            C_TIMEOUT          = 256
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            start,
  input  logic [C_NUM_REGS*32-1:0]        cfg_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [1:0]                      err_code,
  output logic [1:0]                      err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  state_t                  state, state_n;
  logic [1:0]              idx;
  logic [1:0]              err_code_n;
  logic                    aw_done, w_done;
  logic                    aw_hs, w_hs, tmo;
  logic [C_NUM_REGS*32-1:0] cfg_q;
  logic [31:0]             cur_word;

  assign cur_word = cfg_q[32*int'(idx) +: 32];
  assign aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs     = M_AXI_WVALID && M_AXI_WREADY;

  axil_wait_timer #(.C_TIMEOUT(C_TIMEOUT)) u_timer (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .clr     (state_n != state),
    .en      (state inside {WR, WRESP, RD, RDATA}),
    .expired (tmo)
  );

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_n    = state;
    err_code_n = err_code;
    case (state)
      IDLE: if (start) begin
        state_n    = WR;
        err_code_n = ERR_NONE;
      end
      WR: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WRESP;
        else if (tmo) begin err_code_n = ERR_TIMEOUT; state_n = FIN; end
      end
      WRESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP == RESP_OKAY) state_n = RD;
          else begin err_code_n = ERR_RESP; state_n = FIN; end
        end else if (tmo) begin err_code_n = ERR_TIMEOUT; state_n = FIN; end
      end
      RD: begin
        if (M_AXI_ARREADY) state_n = RDATA;
        else if (tmo) begin err_code_n = ERR_TIMEOUT; state_n = FIN; end
      end
      RDATA: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != RESP_OKAY)        begin err_code_n = ERR_RESP; state_n = FIN; end
          else if (M_AXI_RDATA[31:0] != cur_word) begin err_code_n = ERR_CMP;  state_n = FIN; end
          else                                   state_n = NEXT;
        end else if (tmo) begin err_code_n = ERR_TIMEOUT; state_n = FIN; end
      end
      NEXT:    state_n = (idx == 2'(C_NUM_REGS - 1)) ? FIN : WR;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      idx      <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      err_idx  <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      state    <= state_n;
      err_code <= err_code_n;
      aw_done  <= (state == WR) && (state_n == WR) && (aw_done || aw_hs);
      w_done   <= (state == WR) && (state_n == WR) && (w_done || w_hs);
      if (state == IDLE && start) begin
        idx <= '0;
        err <= 1'b0;
      end
      if (state == NEXT && state_n == WR) idx <= idx + 1'b1;
      // err/err_idx land on FIN entry so they are valid alongside the done pulse.
      if (state != FIN && state_n == FIN) begin
        err     <= (err_code_n != ERR_NONE);
        err_idx <= idx;
      end
    end
  end

  // NOTE: the captured config words are plain data behind a qualifier, so they carry no reset.
  always_ff @(posedge ACLK) begin
    if (state == IDLE && start) cfg_q <= cfg_data;
  end

  assign busy          = (state != IDLE);
  assign done          = (state == FIN);
  assign M_AXI_AWADDR  = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx, 2'b00});
  assign M_AXI_ARADDR  = M_AXI_AWADDR;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = (state == WR) && !aw_done;
  assign M_AXI_WVALID  = (state == WR) && !w_done;
  assign M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(cur_word);
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_BREADY  = (state == WRESP);
  assign M_AXI_ARVALID = (state == RD);
  assign M_AXI_RREADY  = (state == RDATA);

endmodule
